// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory freeze sequencing.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
//
// state   | meaning
// RUN     | normal flow, no event last cycle
// LDSTALL | one-cycle load-use bubble; the load is now in MEM, hz ignored
// BRFLUSH | ID holds the flushed NOP; hz ignored
// MEMWAIT | pipeline frozen for data memory; held branch/hazard serviced on release
module pipe_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_ra,
  input  logic [REGW-1:0] id_rb,
  input  logic            id_use_ra,
  input  logic            id_use_rb,
  input  logic            ex_load,
  input  logic [REGW-1:0] ex_dest,
  input  logic            br_taken,
  input  logic            mem_busy,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            pipe_we,
  output logic [1:0]      state,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    BRFLUSH = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   hz;
  logic   hz_live;
  logic   pc_en;

  always_comb begin
    hz = id_valid && ex_load && (ex_dest != '0) &&
         ((id_use_ra && (id_ra == ex_dest)) || (id_use_rb && (id_rb == ex_dest)));
    // The bubble already inserted (or the flushed NOP in ID) makes a second stall pointless.
    hz_live = hz && ((state_q == RUN) || (state_q == MEMWAIT));
  end

  always_comb begin
    state_d     = RUN;
    pc_en       = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_we     = 1'b1;
    if (mem_busy) begin
      state_d = MEMWAIT;
      pc_en   = 1'b0;
      pipe_we = 1'b0;
    end else if (br_taken) begin
      state_d     = BRFLUSH;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hz_live) begin
      state_d     = LDSTALL;
      pc_en       = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign pc_we   = pc_en;
  assign ifid_we = pc_en;
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (!pc_en && (cnt_q != {CNTW{1'b1}}))
      cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against an event-level reference model.
module tb_pipe_ctrl;
  localparam int REGW = 5;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_use_ra, id_use_rb, ex_load, br_taken, mem_busy;
  logic [REGW-1:0] id_ra, id_rb, ex_dest;
  logic            pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we;
  logic [1:0]      state;
  logic [CNTW-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the event chosen last cycle (0 none, 1 load stall, 2 branch, 3 mem wait)
  // and the number of clock edges taken with the PC frozen.
  int prev_ev = 0;
  int cnt     = 0;

  pipe_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_load(ex_load), .ex_dest(ex_dest),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_we(pipe_we),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_count();
`ifdef PIPE_CTRL_PERF_EN
    int maxv = (1 << CNTW) - 1;
    return (cnt > maxv) ? maxv : cnt;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [REGW-1:0] ra, input logic [REGW-1:0] rb,
                       input logic ua, input logic ub, input logic ld,
                       input logic [REGW-1:0] dest, input logic br, input logic mb);
    id_valid = v; id_ra = ra; id_rb = rb; id_use_ra = ua; id_use_rb = ub;
    ex_load = ld; ex_dest = dest; br_taken = br; mem_busy = mb;
  endtask

  task automatic cycle(input logic v, input logic [REGW-1:0] ra, input logic [REGW-1:0] rb,
                       input logic ua, input logic ub, input logic ld,
                       input logic [REGW-1:0] dest, input logic br, input logic mb);
    bit hz, ev_pc;
    int ev;
    @(negedge clk);
    drive(v, ra, rb, ua, ub, ld, dest, br, mb);
    #1;
    hz = v && ld && (dest != 0) && ((ua && ra == dest) || (ub && rb == dest));
    if (mb)                                      ev = 3;
    else if (br)                                 ev = 2;
    else if (hz && prev_ev != 1 && prev_ev != 2) ev = 1;
    else                                         ev = 0;
    ev_pc = (ev == 0) || (ev == 2);
    chk("state", 32'(state), 32'(prev_ev));
    chk("pc_we", 32'(pc_we), 32'(ev_pc));
    chk("ifid_we", 32'(ifid_we), 32'(ev_pc));
    chk("ifid_flush", 32'(ifid_flush), 32'(ev == 2));
    chk("idex_bubble", 32'(idex_bubble), 32'(ev == 1 || ev == 2));
    chk("pipe_we", 32'(pipe_we), 32'(ev != 3));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_count()));
    if (!ev_pc) cnt++;
    prev_ev = ev;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next rising edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    chk("pre_rst_state", 32'(state), 32'(prev_ev));
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    prev_ev = 0;
    cnt     = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc_we", 32'(pc_we), 32'd1);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    drive(1, 5, 0, 1, 0, 1, 5, 0, 0);
    #1;
    chk("reset_hz_pc_we", 32'(pc_we), 32'd0);
    chk("reset_hz_bubble", 32'(idex_bubble), 32'd1);
    @(posedge clk);
    #1;
    chk("reset_hold_state", 32'(state), 32'd0);
    chk("reset_hold_cnt", 32'(stall_cnt), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on ra: single bubble then resume, hazard held through LDSTALL.
    cycle(1, 5, 0, 1, 0, 1, 5, 0, 0);
    cycle(1, 5, 0, 1, 0, 1, 5, 0, 0);
    idle(1);
    // Hazard via rb only, and one with use flag clear.
    cycle(1, 0, 9, 0, 1, 1, 9, 0, 0);
    idle(1);
    cycle(1, 9, 9, 0, 0, 1, 9, 0, 0);
    // ex_dest zero never stalls.
    cycle(1, 0, 0, 1, 1, 1, 0, 0, 0);
    // Branch wins over hazard, back-to-back branches, hazard ignored in BRFLUSH.
    cycle(1, 5, 0, 1, 0, 1, 5, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 5, 0, 1, 0, 1, 5, 0, 0);
    idle(1);
    // Memory freeze with branch held, serviced on release.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // Hazard held through a freeze is serviced on release.
    cycle(1, 3, 0, 1, 0, 1, 3, 0, 1);
    cycle(1, 3, 0, 1, 0, 1, 3, 0, 0);
    idle(1);
    // Long freeze exercises counter saturation.
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    pulse_reset();
    idle(1);
    // Reset in LDSTALL abandons the sequence.
    cycle(1, 7, 0, 1, 0, 1, 7, 0, 0);
    pulse_reset();
    idle(2);

    for (int i = 0; i < 600; i++) begin
      logic [REGW-1:0] ra, rb, dest;
      ra   = REGW'($urandom_range(0, 3));
      rb   = REGW'($urandom_range(0, 3));
      dest = REGW'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
            1'($urandom), dest, 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 4) == 0));
      if (i == 300) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
